// File: rtl/div_sched_if.sv
// Request, dispatch and writeback signals of the divide scheduler.
// The slave modport is the scheduler's view and the master modport is its environment.
// Port suffixes (_i/_o) are given from the scheduler's point of view.
interface div_sched_if #(
    parameter int W     = 32,
    parameter int ROB_W = 6,
    parameter int PRF_W = 7
);
    // Request side: two issue ports feeding the queue
    logic [1:0]       req_valid_i;
    logic [W-1:0]     req_a0_i;
    logic [W-1:0]     req_a1_i;
    logic [W-1:0]     req_b0_i;
    logic [W-1:0]     req_b1_i;
    logic [1:0]       req_signed_i;
    logic [1:0]       req_rem_i;
    logic [ROB_W-1:0] req_rob0_i;
    logic [ROB_W-1:0] req_rob1_i;
    logic [PRF_W-1:0] req_prf0_i;
    logic [PRF_W-1:0] req_prf1_i;
    logic             req_ready_o;
    logic             flush_i;

    // Dispatch bundle to the iterative divider
    logic             div_start_o;
    logic [W-1:0]     div_a_o;
    logic [W-1:0]     div_b_o;
    logic             div_signed_o;
    logic             div_rem_o;
    logic [ROB_W-1:0] div_rob_o;
    logic [PRF_W-1:0] div_prf_o;

    // Divider status and result
    logic             div_ready_i;
    logic             div_complete_i;
    logic [W-1:0]     div_y_i;
    logic [ROB_W-1:0] div_rob_i;
    logic [PRF_W-1:0] div_prf_i;

    // Registered writeback to the PRF/ROB
    logic             res_valid_o;
    logic [W-1:0]     res_y_o;
    logic [ROB_W-1:0] res_rob_o;
    logic [PRF_W-1:0] res_prf_o;

    modport slave (
        input  req_valid_i, req_a0_i, req_a1_i, req_b0_i, req_b1_i,
        input  req_signed_i, req_rem_i, req_rob0_i, req_rob1_i, req_prf0_i, req_prf1_i,
        output req_ready_o,
        input  flush_i,
        output div_start_o, div_a_o, div_b_o, div_signed_o, div_rem_o, div_rob_o, div_prf_o,
        input  div_ready_i, div_complete_i, div_y_i, div_rob_i, div_prf_i,
        output res_valid_o, res_y_o, res_rob_o, res_prf_o
    );

    modport master (
        output req_valid_i, req_a0_i, req_a1_i, req_b0_i, req_b1_i,
        output req_signed_i, req_rem_i, req_rob0_i, req_rob1_i, req_prf0_i, req_prf1_i,
        input  req_ready_o,
        output flush_i,
        input  div_start_o, div_a_o, div_b_o, div_signed_o, div_rem_o, div_rob_o, div_prf_o,
        output div_ready_i, div_complete_i, div_y_i, div_rob_i, div_prf_i,
        input  res_valid_o, res_y_o, res_rob_o, res_prf_o
    );
endinterface

// File: rtl/div_sched.sv
// Divide scheduler: queues requests from two issue ports, feeds one iterative
// divider at a time and registers its result for writeback.
// Optional feature: define DIV_ZERO_BYPASS_EN to answer divide-by-zero requests
// directly from the queue instead of sending them to the divider.
module div_sched #(
    parameter int LG_W           = 5,
    parameter int LG_Q           = 2,
    parameter int LG_ROB_ENTRIES = 6,
    parameter int LG_PRF_ENTRIES = 7
) (
    input  logic       clk,
    input  logic       reset,
    div_sched_if.slave bus
);
    localparam int W = 1 << LG_W;
    localparam int Q = 1 << LG_Q;

    typedef struct packed {
        logic [W-1:0]              a;
        logic [W-1:0]              b;
        logic                      sgn;
        logic                      rem;
        logic [LG_ROB_ENTRIES-1:0] rob;
        logic [LG_PRF_ENTRIES-1:0] prf;
    } entry_t;

    typedef enum logic [1:0] {IDLE, BUSY, KILLED} state_t;

    entry_t                    queue_q [Q];
    logic [LG_Q-1:0]           headPtr_q, headPtr_d;
    logic [LG_Q-1:0]           tailPtr_q, tailPtr_d;
    logic [LG_Q:0]             count_q, count_d;
    state_t                    state_q, state_d;
    logic                      resValid_q, resValid_d;
    logic [W-1:0]              resY_q, resY_d;
    logic [LG_ROB_ENTRIES-1:0] resRob_q, resRob_d;
    logic [LG_PRF_ENTRIES-1:0] resPrf_q, resPrf_d;

    entry_t headEntry, entry0, entry1;
    logic   reqReady, enq0, enq1, queueEmpty, headZero, divStart, bypassPop, doPop;

    // Enqueue/dispatch decisions; an entry is accepted only when two slots are free
    always_comb begin
        headEntry  = queue_q[headPtr_q];
        entry0     = '{a: bus.req_a0_i, b: bus.req_b0_i, sgn: bus.req_signed_i[0],
                       rem: bus.req_rem_i[0], rob: bus.req_rob0_i, prf: bus.req_prf0_i};
        entry1     = '{a: bus.req_a1_i, b: bus.req_b1_i, sgn: bus.req_signed_i[1],
                       rem: bus.req_rem_i[1], rob: bus.req_rob1_i, prf: bus.req_prf1_i};
        queueEmpty = (count_q == '0);
        reqReady   = reset || (count_q <= (LG_Q+1)'(Q - 2));
        enq0       = bus.req_valid_i[0] && reqReady && !bus.flush_i;
        enq1       = bus.req_valid_i[1] && reqReady && !bus.flush_i;
`ifdef DIV_ZERO_BYPASS_EN
        headZero   = (headEntry.b == '0);
`else
        headZero   = 1'b0;
`endif
        divStart   = !reset && !queueEmpty && bus.div_ready_i && (state_q == IDLE)
                     && !bus.flush_i && !headZero;
        bypassPop  = !reset && !queueEmpty && (state_q == IDLE) && !bus.flush_i && headZero;
        doPop      = divStart || bypassPop;
    end

    // Pointer and occupancy bookkeeping; port 0 takes the older slot, flush empties the queue
    always_comb begin
        tailPtr_d = tailPtr_q + LG_Q'(enq0) + LG_Q'(enq1);
        headPtr_d = headPtr_q + LG_Q'(doPop);
        count_d   = count_q + (LG_Q+1)'(enq0) + (LG_Q+1)'(enq1) - (LG_Q+1)'(doPop);
        if (bus.flush_i) begin
            tailPtr_d = '0;
            headPtr_d = '0;
            count_d   = '0;
        end
    end

    // Outstanding-divide tracker; a flush during a divide marks its result for discard
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (divStart) state_d = BUSY;
            BUSY: begin
                if (bus.div_complete_i)  state_d = IDLE;
                else if (bus.flush_i)    state_d = KILLED;
            end
            KILLED:  if (bus.div_complete_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writeback capture from the divider or from the zero-divisor bypass
    always_comb begin
        resValid_d = 1'b0;
        resY_d     = resY_q;
        resRob_d   = resRob_q;
        resPrf_d   = resPrf_q;
        if ((state_q == BUSY) && bus.div_complete_i && !bus.flush_i) begin
            resValid_d = 1'b1;
            resY_d     = bus.div_y_i;
            resRob_d   = bus.div_rob_i;
            resPrf_d   = bus.div_prf_i;
        end else if (bypassPop) begin
            resValid_d = 1'b1;
            resY_d     = headEntry.rem ? headEntry.a : '1;
            resRob_d   = headEntry.rob;
            resPrf_d   = headEntry.prf;
        end
    end

    // Queue storage writes; payload needs no reset because occupancy guards it
    always_ff @(posedge clk) begin
        if (enq0) queue_q[tailPtr_q] <= entry0;
        if (enq1) queue_q[tailPtr_q + LG_Q'(enq0)] <= entry1;
    end

    // Control and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr_q  <= '0;
            tailPtr_q  <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            resValid_q <= 1'b0;
            resY_q     <= '0;
            resRob_q   <= '0;
            resPrf_q   <= '0;
        end else begin
            headPtr_q  <= headPtr_d;
            tailPtr_q  <= tailPtr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            resValid_q <= resValid_d;
            resY_q     <= resY_d;
            resRob_q   <= resRob_d;
            resPrf_q   <= resPrf_d;
        end
    end

    assign bus.req_ready_o  = reqReady;
    assign bus.div_start_o  = divStart;
    assign bus.div_a_o      = headEntry.a;
    assign bus.div_b_o      = headEntry.b;
    assign bus.div_signed_o = headEntry.sgn;
    assign bus.div_rem_o    = headEntry.rem;
    assign bus.div_rob_o    = headEntry.rob;
    assign bus.div_prf_o    = headEntry.prf;
    assign bus.res_valid_o  = resValid_q;
    assign bus.res_y_o      = resY_q;
    assign bus.res_rob_o    = resRob_q;
    assign bus.res_prf_o    = resPrf_q;
endmodule

// File: tb/tb_div_sched.sv
// Directed testbench for div_sched; the divider is played by the bench itself.
// Build with DIV_ZERO_BYPASS_EN defined to exercise the zero-divisor bypass.
module tb_div_sched;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    div_sched_if #(.W(32), .ROB_W(6), .PRF_W(7)) bus ();

    div_sched #(
        .LG_W(5), .LG_Q(2), .LG_ROB_ENTRIES(6), .LG_PRF_ENTRIES(7)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes
    task automatic settle();
        #2;
    endtask

    // Present one request on a port; prf tag is derived from the rob tag
    task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] b,
                                 input logic rem, input logic [5:0] rob);
        bus.req_valid_i[port]  = 1'b1;
        bus.req_signed_i[port] = 1'b0;
        bus.req_rem_i[port]    = rem;
        if (port == 0) begin
            bus.req_a0_i = a; bus.req_b0_i = b; bus.req_rob0_i = rob; bus.req_prf0_i = {1'b0, rob} + 7'd1;
        end else begin
            bus.req_a1_i = a; bus.req_b1_i = b; bus.req_rob1_i = rob; bus.req_prf1_i = {1'b0, rob} + 7'd1;
        end
    endtask

    // Drop requests, flush and the completion pulse
    task automatic releaseInputs();
        bus.req_valid_i    = 2'b00;
        bus.flush_i        = 1'b0;
        bus.div_complete_i = 1'b0;
    endtask

    // Raise the divider completion pulse with its result and tags
    task automatic pulseComplete(input logic [31:0] y, input logic [5:0] rob);
        bus.div_complete_i = 1'b1;
        bus.div_y_i        = y;
        bus.div_rob_i      = rob;
        bus.div_prf_i      = {1'b0, rob} + 7'd1;
    endtask

    initial begin
        bus.req_a0_i = '0; bus.req_a1_i = '0; bus.req_b0_i = '0; bus.req_b1_i = '0;
        bus.req_signed_i = '0; bus.req_rem_i = '0;
        bus.req_rob0_i = '0; bus.req_rob1_i = '0; bus.req_prf0_i = '0; bus.req_prf1_i = '0;
        bus.div_ready_i = 1'b0; bus.div_y_i = '0; bus.div_rob_i = '0; bus.div_prf_i = '0;
        releaseInputs();

        // Reset state
        reset = 1'b1;
        step(); step();
        settle();
        checkOutput("rst_res_valid", 64'(bus.res_valid_o), 64'd0);
        checkOutput("rst_res_y",     64'(bus.res_y_o),     64'd0);
        checkOutput("rst_res_rob",   64'(bus.res_rob_o),   64'd0);
        checkOutput("rst_res_prf",   64'(bus.res_prf_o),   64'd0);
        checkOutput("rst_div_start", 64'(bus.div_start_o), 64'd0);
        checkOutput("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        reset = 1'b0;
        step();

        // Single divide 100/7 on port 0
        bus.div_ready_i = 1'b1;
        applyStimulus(0, 32'd100, 32'd7, 1'b0, 6'd3);
        settle();
        checkOutput("one_start_empty", 64'(bus.div_start_o), 64'd0);
        checkOutput("one_req_ready",   64'(bus.req_ready_o), 64'd1);
        step();
        releaseInputs();
        settle();
        checkOutput("one_start", 64'(bus.div_start_o), 64'd1);
        checkOutput("one_a",     64'(bus.div_a_o),     64'd100);
        checkOutput("one_b",     64'(bus.div_b_o),     64'd7);
        checkOutput("one_rob",   64'(bus.div_rob_o),   64'd3);
        step();
        bus.div_ready_i = 1'b0;
        settle();
        checkOutput("one_start_busy", 64'(bus.div_start_o), 64'd0);
        step();
        pulseComplete(32'd14, 6'd3);
        settle();
        checkOutput("one_res_early", 64'(bus.res_valid_o), 64'd0);
        step();
        releaseInputs();
        bus.div_ready_i = 1'b1;
        settle();
        checkOutput("one_res_valid", 64'(bus.res_valid_o), 64'd1);
        checkOutput("one_res_y",     64'(bus.res_y_o),     64'd14);
        checkOutput("one_res_rob",   64'(bus.res_rob_o),   64'd3);
        checkOutput("one_res_prf",   64'(bus.res_prf_o),   64'd4);
        checkOutput("one_start_none", 64'(bus.div_start_o), 64'd0);
        step();
        settle();
        checkOutput("one_res_pulse", 64'(bus.res_valid_o), 64'd0);

        // Dual-port enqueue: rob 1 dispatches before rob 2
        applyStimulus(0, 32'd10, 32'd2, 1'b0, 6'd1);
        applyStimulus(1, 32'd20, 32'd4, 1'b0, 6'd2);
        step();
        releaseInputs();
        settle();
        checkOutput("dual_start1", 64'(bus.div_start_o), 64'd1);
        checkOutput("dual_rob1",   64'(bus.div_rob_o),   64'd1);
        checkOutput("dual_a1",     64'(bus.div_a_o),     64'd10);
        step();
        settle();
        checkOutput("dual_hold", 64'(bus.div_start_o), 64'd0);
        step();
        pulseComplete(32'd5, 6'd1);
        settle();
        checkOutput("dual_hold_cmp", 64'(bus.div_start_o), 64'd0);
        step();
        releaseInputs();
        settle();
        checkOutput("dual_start2",  64'(bus.div_start_o), 64'd1);
        checkOutput("dual_rob2",    64'(bus.div_rob_o),   64'd2);
        checkOutput("dual_a2",      64'(bus.div_a_o),     64'd20);
        checkOutput("dual_res1_v",  64'(bus.res_valid_o), 64'd1);
        checkOutput("dual_res1_rob", 64'(bus.res_rob_o),  64'd1);
        step();
        bus.div_ready_i = 1'b0;
        pulseComplete(32'd5, 6'd2);
        step();
        releaseInputs();
        settle();
        checkOutput("dual_res2_rob", 64'(bus.res_rob_o), 64'd2);
        step();

        // Fill the queue with the divider held off; extra requests are dropped
        applyStimulus(0, 32'd40, 32'd1, 1'b0, 6'd4);
        applyStimulus(1, 32'd50, 32'd1, 1'b0, 6'd5);
        settle();
        checkOutput("fill_ready0", 64'(bus.req_ready_o), 64'd1);
        step();
        applyStimulus(0, 32'd60, 32'd1, 1'b0, 6'd6);
        applyStimulus(1, 32'd70, 32'd1, 1'b0, 6'd7);
        settle();
        checkOutput("fill_ready2", 64'(bus.req_ready_o), 64'd1);
        step();
        applyStimulus(0, 32'd80, 32'd1, 1'b0, 6'd8);
        applyStimulus(1, 32'd90, 32'd1, 1'b0, 6'd9);
        settle();
        checkOutput("fill_ready4", 64'(bus.req_ready_o), 64'd0);
        step();
        releaseInputs();
        settle();
        checkOutput("fill_ready4b", 64'(bus.req_ready_o), 64'd0);
        for (int k = 0; k < 4; k++) begin
            bus.div_ready_i = 1'b1;
            settle();
            checkOutput($sformatf("drain_start%0d", k), 64'(bus.div_start_o), 64'd1);
            checkOutput($sformatf("drain_rob%0d", k),   64'(bus.div_rob_o),   64'(4 + k));
            if (k > 0)
                checkOutput($sformatf("drain_res%0d", k), 64'(bus.res_rob_o), 64'(3 + k));
            step();
            bus.div_ready_i = 1'b0;
            pulseComplete(32'(k), 6'(4 + k));
            settle();
            checkOutput($sformatf("drain_ready%0d", k), 64'(bus.req_ready_o), (k >= 1) ? 64'd1 : 64'd0);
            step();
            releaseInputs();
        end
        bus.div_ready_i = 1'b1;
        settle();
        checkOutput("drain_empty",   64'(bus.div_start_o), 64'd0);
        checkOutput("drain_res_last", 64'(bus.res_rob_o),  64'd7);
        step();

        // Flush while busy with two entries queued
        applyStimulus(0, 32'd30, 32'd3, 1'b0, 6'd10);
        applyStimulus(1, 32'd40, 32'd4, 1'b0, 6'd11);
        step();
        releaseInputs();
        applyStimulus(0, 32'd50, 32'd5, 1'b0, 6'd12);
        settle();
        checkOutput("fl_start", 64'(bus.div_start_o), 64'd1);
        checkOutput("fl_rob",   64'(bus.div_rob_o),   64'd10);
        step();
        releaseInputs();
        bus.div_ready_i = 1'b0;
        bus.flush_i = 1'b1;
        step();
        releaseInputs();
        bus.div_ready_i = 1'b1;
        settle();
        checkOutput("fl_empty_start", 64'(bus.div_start_o), 64'd0);
        checkOutput("fl_ready",       64'(bus.req_ready_o), 64'd1);
        step();
        pulseComplete(32'd55, 6'd10);
        settle();
        checkOutput("fl_killed_start", 64'(bus.div_start_o), 64'd0);
        step();
        releaseInputs();
        settle();
        checkOutput("fl_res_killed", 64'(bus.res_valid_o), 64'd0);
        applyStimulus(0, 32'd60, 32'd6, 1'b0, 6'd13);
        step();
        releaseInputs();
        settle();
        checkOutput("fl_next_start", 64'(bus.div_start_o), 64'd1);
        checkOutput("fl_next_rob",   64'(bus.div_rob_o),   64'd13);
        checkOutput("fl_next_a",     64'(bus.div_a_o),     64'd60);
        step();
        bus.div_ready_i = 1'b0;
        pulseComplete(32'd10, 6'd13);
        step();
        releaseInputs();
        settle();
        checkOutput("fl_next_res_v", 64'(bus.res_valid_o), 64'd1);
        checkOutput("fl_next_res_y", 64'(bus.res_y_o),     64'd10);
        step();

        // Flush coincident with completion and with an enqueue
        bus.div_ready_i = 1'b1;
        applyStimulus(0, 32'd70, 32'd7, 1'b0, 6'd14);
        step();
        releaseInputs();
        settle();
        checkOutput("fc_start", 64'(bus.div_start_o), 64'd1);
        step();
        bus.flush_i = 1'b1;
        pulseComplete(32'd99, 6'd14);
        applyStimulus(0, 32'd80, 32'd8, 1'b0, 6'd15);
        step();
        releaseInputs();
        settle();
        checkOutput("fc_res_v",  64'(bus.res_valid_o), 64'd0);
        checkOutput("fc_no_enq", 64'(bus.div_start_o), 64'd0);
        step();
        settle();
        checkOutput("fc_no_enq2", 64'(bus.div_start_o), 64'd0);
        step();

`ifdef DIV_ZERO_BYPASS_EN
        // Zero divisors answered by the bypass, never dispatched
        applyStimulus(0, 32'd5, 32'd0, 1'b0, 6'd20);
        applyStimulus(1, 32'd5, 32'd0, 1'b1, 6'd21);
        step();
        releaseInputs();
        settle();
        checkOutput("bz_start0", 64'(bus.div_start_o), 64'd0);
        step();
        settle();
        checkOutput("bz_res0_v",   64'(bus.res_valid_o), 64'd1);
        checkOutput("bz_res0_y",   64'(bus.res_y_o),     64'hFFFF_FFFF);
        checkOutput("bz_res0_rob", 64'(bus.res_rob_o),   64'd20);
        checkOutput("bz_start1",   64'(bus.div_start_o), 64'd0);
        step();
        settle();
        checkOutput("bz_res1_v",   64'(bus.res_valid_o), 64'd1);
        checkOutput("bz_res1_y",   64'(bus.res_y_o),     64'd5);
        checkOutput("bz_res1_rob", 64'(bus.res_rob_o),   64'd21);
        step();
        settle();
        checkOutput("bz_res_done", 64'(bus.res_valid_o), 64'd0);
`else
        // Zero divisors go to the divider like any other request
        applyStimulus(0, 32'd5, 32'd0, 1'b0, 6'd20);
        step();
        releaseInputs();
        settle();
        checkOutput("z_start", 64'(bus.div_start_o), 64'd1);
        checkOutput("z_b",     64'(bus.div_b_o),     64'd0);
        checkOutput("z_a",     64'(bus.div_a_o),     64'd5);
        step();
        bus.div_ready_i = 1'b0;
        pulseComplete(32'hFFFF_FFFF, 6'd20);
        step();
        releaseInputs();
        settle();
        checkOutput("z_res_y", 64'(bus.res_y_o), 64'hFFFF_FFFF);
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter LG_W, default 5, log2 of operand width W; W=32.
REQ-002 Parameter LG_Q, default 2, log2 of request queue depth Q; Q=4, and Q SHALL be at least 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-port divide request; bit0 = port 0, bit1 = port 1.
REQ-006 req_a0, req_a1  input  W  dividend for each port.
REQ-007 req_b0, req_b1  input  W  divisor for each port.
REQ-008 req_signed, req_rem  input  2 each  signed-divide flag and remainder-select flag, one bit per port.
REQ-009 req_rob0, req_rob1  input  LG_ROB_ENTRIES  ROB tag for each port.
REQ-010 req_prf0, req_prf1  input  LG_PRF_ENTRIES  destination PRF tag for each port.
REQ-011 req_ready  output  1  high when at least 2 queue slots are free.
REQ-012 flush  input  1  pipeline flush; kills all queued and in-flight work.
REQ-013 div_start, div_a, div_b, div_signed, div_rem, div_rob, div_prf  output  1/W/W/1/1/ROB/PRF  dispatch bundle to the iterative divider.
REQ-014 div_ready, div_complete  input  1 each  divider idle indication and one-cycle done pulse.
REQ-015 div_y, div_rob, div_prf  input  W/ROB/PRF  divider result and tags; sampled only when div_complete=1.
REQ-016 res_valid, res_y, res_rob, res_prf  output  1/W/ROB/PRF  registered writeback to the PRF/ROB.

Function
REQ-017 The request queue SHALL be a FIFO of Q entries with head/tail pointers and an occupancy count of LG_Q+1 bits.
REQ-018 Pointers SHALL wrap modulo Q.
REQ-019 A port's request SHALL be enqueued when its req_valid bit is 1, req_ready is 1 and flush is 0; requests presented while req_ready=0 or flush=1 SHALL be dropped.
REQ-020 When both ports enqueue in the same cycle, port 0 SHALL occupy the lower (older) slot.
REQ-021 A dispatch SHALL occur when the queue is non-empty, div_ready=1, r_busy=0 and flush=0.
REQ-022 On a dispatch, div_start=1 SHALL be asserted combinationally with the head entry on the div_* bundle, and the head SHALL pop in the same cycle.
REQ-023 In every other cycle, div_start SHALL be 0.
REQ-024 r_busy SHALL set on dispatch and clear on the cycle after div_complete, so at most one divide is outstanding.
REQ-025 An enqueue and a pop in the same cycle SHALL leave the count unchanged.
REQ-026 In a cycle with div_complete=1, the scheduler SHALL register the result as res_valid=1, res_y=div_y, res_rob=div_rob, res_prf=div_prf, visible the next cycle for exactly one cycle.
REQ-027 Flush SHALL empty the queue (pointers and count to 0).
REQ-028 Flush while r_busy=1 SHALL set r_kill; the next div_complete SHALL produce no res_valid and SHALL clear r_kill and r_busy.
REQ-029 Flush coincident with div_complete SHALL suppress that result.
REQ-030 Flush SHALL NOT retract a res_valid that is already registered.
REQ-031 States SHALL be IDLE (r_busy=0), BUSY (r_busy=1, r_kill=0) and KILLED (r_busy=1, r_kill=1).
REQ-032 State transitions SHALL be: IDLE->BUSY on dispatch; BUSY->IDLE on div_complete; BUSY->KILLED on flush; KILLED->IDLE on div_complete.

Reset
REQ-033 While reset=1: queue empty; r_busy=0; r_kill=0; res_valid=0; res_y, res_rob and res_prf all 0; div_start=0; req_ready=1.
REQ-034 Reset mid-divide SHALL discard the in-flight result; the divider is reset by the same signal.

Configuration
REQ-035 The macro DIV_ZERO_BYPASS_EN SHALL enable the divide-by-zero bypass.
REQ-036 With DIV_ZERO_BYPASS_EN defined: a head entry with divisor 0 SHALL NOT be dispatched; when r_busy=0 and flush=0 it SHALL pop and register res_valid=1 next cycle with res_y = dividend if rem, else all-ones, and the entry's tags.
REQ-037 With DIV_ZERO_BYPASS_EN defined, the divider SHALL never see a zero divisor.
REQ-038 Without DIV_ZERO_BYPASS_EN, zero divisors SHALL be dispatched like any other request.

Verification
REQ-039 Port0 a=100,b=7,rob=3 enqueued; divider completes with y=14 -> div_start once with a=100, b=7; res_valid one cycle, res_y=14, res_rob=3.
REQ-040 Both ports valid in the same cycle (rob 1, rob 2) -> dispatch order is rob 1 then rob 2; second div_start only after the first div_complete.
REQ-041 Fill 4 entries with div_ready=0 -> req_ready=0 at count>=3; further requests dropped; count never exceeds 4.
REQ-042 Flush while BUSY with 2 queued -> queue empties; the following div_complete yields res_valid=0; next request dispatches normally.
REQ-043 Flush coincident with div_complete and with an enqueue -> no res_valid, no enqueue.
REQ-044 DIV_ZERO_BYPASS_EN defined, a=5,b=0,rem=0 then rem=1 -> results 0xFFFFFFFF then 5, with no div_start; macro undefined -> div_start asserted with b=0.
